// File: rtl/adc_sample_averager.sv
// Request scheduler and running averager around the serial ADC receiver.
// Define AVG_ROUND_EN for round-half-up averaging; truncation otherwise.
module adc_sample_averager #(
  parameter logic [15:0] PERIOD   = 16'd800,
  parameter int          LOG2_AVG = 3,
  parameter logic [9:0]  TIMEOUT  = 10'd600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] spiData,
  input  logic        spiReady,
  output logic        dataRequest,
  output logic [11:0] avgData,
  output logic        avgValid,
  output logic        timeoutErr
);
  localparam int CNT_W = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
  localparam int ACC_W = 12 + LOG2_AVG;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
`ifdef AVG_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'((1 << LOG2_AVG) >> 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif
  localparam logic [15:0] PER_LAST = PERIOD - 16'd1;
  localparam logic [9:0]  TMO_LAST = TIMEOUT - 10'd1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic             rdyD;
  logic             rdyEdge;
  logic             stop;
  logic [1:0]       rq;
  logic [15:0]      per;
  logic [9:0]       tmo;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  function automatic logic [11:0] round_avg(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] biased;
    biased = sum + RND;
    return biased[LOG2_AVG +: 12];
  endfunction

  assign rdyEdge = spiReady & ~rdyD;
  assign stop    = !enable && (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    dataRequest = 1'b0;
    case (state)
      S_IDLE: if (enable) state_nxt = S_REQ;
      S_REQ: begin
        dataRequest = 1'b1;
        if (rq == 2'd3) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rdyEdge) state_nxt = (cnt == CNT_LAST) ? S_DONE : S_HOLD;
        else if (tmo == TMO_LAST) state_nxt = S_HOLD;
      end
      S_DONE: state_nxt = S_HOLD;
      S_HOLD: if (per >= PER_LAST) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    if (stop) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      rdyD  <= 1'b0;
    end else begin
      state <= state_nxt;
      rdyD  <= spiReady;
    end
  end

  // schedule counters: request width, period (saturating), reply timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq  <= '0;
      per <= '0;
      tmo <= '0;
    end else begin
      if (state_nxt == S_REQ && state != S_REQ) begin
        rq  <= '0;
        per <= '0;
      end else begin
        if (state == S_REQ) rq <= rq + 2'd1;
        if (state != S_IDLE && per != PER_LAST) per <= per + 16'd1;
      end
      if (state == S_REQ) tmo <= '0;
      else if (state == S_WAIT) tmo <= tmo + 10'd1;
    end
  end

  // accumulation and average output; a dropped enable discards the partial sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      cnt        <= '0;
      avgData    <= '0;
      avgValid   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      avgValid   <= 1'b0;
      timeoutErr <= 1'b0;
      if (stop) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == S_WAIT) begin
        if (rdyEdge) begin
          acc <= acc + ACC_W'(spiData);
          if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
        end else if (tmo == TMO_LAST) begin
          timeoutErr <= 1'b1;
        end
      end else if (state == S_DONE) begin
        avgData  <= round_avg(acc);
        avgValid <= 1'b1;
        acc      <= '0;
        cnt      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboarded bench for adc_sample_averager: a reply model drives the receiver side
// and queues expected averages, timeouts and request starts; a monitor compares them.
module tb_adc_sample_averager;
  localparam int PER  = 800;
  localparam int TMO  = 600;
  localparam int NAVG = 8;
`ifdef AVG_ROUND_EN
  localparam int RND = NAVG / 2;
`else
  localparam int RND = 0;
`endif

  typedef struct { bit reply; bit pre; bit dis; int d; int hold; int val; } plan_t;
  typedef struct { int val; int cyc; } avg_t;

  logic        clk = 1'b0;
  logic        reset, enable, spiReady, dataRequest, avgValid, timeoutErr;
  logic [11:0] spiData, avgData;
  logic        en2, rdy2, req2, av2, te2;
  logic [11:0] data2, avg2;

  int    cyc = 0;
  int    n_chk = 0, n_pass = 0;
  plan_t plan[$];
  avg_t  avg_q[$];
  int    tmo_q[$], rise_q[$], rise2_q[$];
  int    n_rise = 0, rise_cyc = 0, n_rise2 = 0, rise2_cyc = 0;
  int    m_sum = 0, m_n = 0, last_avg = 0;
  bit    done2 = 1'b0;
  bit    rp = 1'b0, rp2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_averager dut (
    .clk(clk), .reset(reset), .enable(enable), .spiData(spiData), .spiReady(spiReady),
    .dataRequest(dataRequest), .avgData(avgData), .avgValid(avgValid), .timeoutErr(timeoutErr)
  );

  // long timeout so a reply later than PERIOD is accepted and the next request is deferred
  adc_sample_averager #(.PERIOD(16'd800), .LOG2_AVG(3), .TIMEOUT(10'd1000)) dut_defer (
    .clk(clk), .reset(reset), .enable(en2), .spiData(data2), .spiReady(rdy2),
    .dataRequest(req2), .avgData(avg2), .avgValid(av2), .timeoutErr(te2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic plan_t mk(input bit reply, input bit pre, input bit dis,
                               input int d, input int hold, input int val);
    plan_t p;
    p.reply = reply; p.pre = pre; p.dis = dis; p.d = d; p.hold = hold; p.val = val;
    return p;
  endfunction

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : monitor
    avg_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (dataRequest && !rp) begin
          rise_cyc = cyc;
          n_rise++;
          if (rise_q.size() == 0) flag("unexpected_request");
          else check("request_rise_cycle", cyc, rise_q.pop_front());
        end
        if (!dataRequest && rp) check("request_width", cyc - rise_cyc, 4);
        if (avgValid) begin
          if (avg_q.size() == 0) flag("unexpected_avgValid");
          else begin
            e = avg_q.pop_front();
            check("avg_value", int'(avgData), e.val);
            check("avg_cycle", cyc, e.cyc);
          end
        end
        if (timeoutErr) begin
          if (tmo_q.size() == 0) flag("unexpected_timeoutErr");
          else check("timeout_cycle", cyc, tmo_q.pop_front());
        end
        if (req2 && !rp2) begin
          rise2_cyc = cyc;
          n_rise2++;
          if (rise2_q.size() == 0) flag("unexpected_request_deferred");
          else check("deferred_rise_cycle", cyc, rise2_q.pop_front());
        end
        if (av2 || te2) flag("unexpected_output_deferred");
      end
      rp  = dataRequest;
      rp2 = req2;
    end
  end

  initial begin : deferred
    int s2, c2;
    en2 = 1'b0; rdy2 = 1'b0; data2 = 12'd0;
    @(posedge reset);
    #1;
    c2 = cyc + 2;
    wait_until(c2);
    rise2_q.push_back(c2 + 1);
    en2 = 1'b1;
    c2 = 0;
    while (n_rise2 == 0 && c2 < 100) begin @(negedge clk); c2++; end
    if (n_rise2 == 0) flag("deferred_first_request_missing");
    s2 = rise2_cyc;
    // reply 900 cycles after the request start: the next request follows HOLD entry by one cycle
    wait_until(s2 + 900);
    data2 = 12'd1234;
    rdy2  = 1'b1;
    rise2_q.push_back(s2 + 902);
    wait_until(s2 + 903);
    rdy2 = 1'b0;
    c2 = 0;
    while (n_rise2 < 2 && c2 < 200) begin @(negedge clk); c2++; end
    if (n_rise2 < 2) flag("deferred_second_request_missing");
    en2 = 1'b0;
    check("deferred_avgData", int'(avg2), 0);
    done2 = 1'b1;
  end

  initial begin : main
    int s, f, t, hold, c, seen;
    plan_t p;
    avg_t  e;

    for (int i = 0; i < NAVG; i++)
      plan.push_back(mk(1, 0, 0, $urandom_range(0, 300), $urandom_range(1, 4), 100 + i));
    for (int i = 0; i < NAVG + 1; i++)
      if (i == 2) plan.push_back(mk(0, 0, 0, 0, 0, 0));
      else plan.push_back(mk(1, 0, 0, $urandom_range(0, 500), $urandom_range(1, 4), 4095));
    for (int i = 0; i < NAVG; i++)
      plan.push_back(mk(1, 1, 0, $urandom_range(5, 400), 4, $urandom_range(0, 4095)));
    for (int i = 0; i < 2 * NAVG; i++) begin
      if ($urandom_range(0, 5) == 0) plan.push_back(mk(0, 0, 0, 0, 0, 0));
      if (i == 0)      c = 0;
      else if (i == 1) c = TMO - 1;
      else             c = $urandom_range(0, 590);
      plan.push_back(mk(1, 0, 0, c, $urandom_range(1, 4), $urandom_range(0, 4095)));
    end
    for (int i = 0; i < 5; i++)
      plan.push_back(mk(1, 0, 0, $urandom_range(0, 500), $urandom_range(1, 4), $urandom_range(0, 4095)));
    plan.push_back(mk(1, 0, 1, 100, 2, 999));
    for (int i = 0; i < NAVG; i++)
      plan.push_back(mk(1, 0, 0, $urandom_range(0, 500), $urandom_range(1, 4), 200));

    reset = 1'b0; enable = 1'b1; spiReady = 1'b0; spiData = 12'd0;
    repeat (3) begin
      @(negedge clk);
      check("reset_dataRequest", int'(dataRequest), 0);
      check("reset_avgData", int'(avgData), 0);
      check("reset_avgValid", int'(avgValid), 0);
      check("reset_timeoutErr", int'(timeoutErr), 0);
    end
    c = cyc + 1;
    wait_until(c);
    rise_q.push_back(c + 1);
    reset = 1'b1;

    seen = 0;
    while (plan.size() > 0) begin
      c = 0;
      while (n_rise == seen && c < 2000) begin @(negedge clk); c++; end
      if (n_rise == seen) begin
        flag("request_never_came");
        break;
      end
      seen = n_rise;
      s = rise_cyc;
      f = s + 4;
      p = plan.pop_front();
      if (p.dis) begin
        wait_until(s + 20);
        enable = 1'b0;
        m_sum = 0;
        m_n = 0;
      end
      if (p.pre) begin
        wait_until(s + 2);
        spiReady = 1'b1;
        wait_until(f + 3);
        spiReady = 1'b0;
      end
      if (!p.reply) begin
        tmo_q.push_back(f + TMO);
        rise_q.push_back(s + PER);
      end else begin
        t = f + p.d;
        wait_until(t);
        spiData  = 12'(p.val);
        spiReady = 1'b1;
        if (!p.dis) begin
          m_sum += p.val;
          m_n++;
          hold = t + 1;
          if (m_n == NAVG) begin
            last_avg = (m_sum + RND) / NAVG;
            e.val = last_avg;
            e.cyc = t + 2;
            avg_q.push_back(e);
            m_sum = 0;
            m_n = 0;
            hold = t + 2;
          end
          rise_q.push_back((s + PER > hold + 1) ? s + PER : hold + 1);
        end
        wait_until(t + p.hold);
        spiReady = 1'b0;
        spiData  = 12'($urandom);
      end
      if (p.dis) begin
        @(negedge clk);
        check("avgData_retained_while_disabled", int'(avgData), last_avg);
        c = cyc + 10;
        wait_until(c);
        rise_q.push_back(c + 1);
        enable = 1'b1;
      end
    end

    // the final request is left unanswered; reset hits while it is still being issued
    c = 0;
    while (rise_q.size() > 0 && c < 1000) begin @(negedge clk); c++; end
    check("pending_rise_expectations", rise_q.size(), 0);
    #2;
    check("dataRequest_before_async_reset", int'(dataRequest), 1);
    check("avgData_before_async_reset", int'(avgData), last_avg);
    reset = 1'b0;
    #1;
    check("async_reset_dataRequest", int'(dataRequest), 0);
    check("async_reset_avgData", int'(avgData), 0);
    check("async_reset_avgValid", int'(avgValid), 0);
    check("async_reset_timeoutErr", int'(timeoutErr), 0);
    check("pending_avg", avg_q.size(), 0);
    check("pending_timeout", tmo_q.size(), 0);
    c = 0;
    while (!done2 && c < 3000) begin @(negedge clk); c++; end
    if (!done2) flag("deferred_scenario_incomplete");
    check("pending_rise_deferred", rise2_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Request scheduler and sample averager placed directly upstream and downstream of the serial ADC receiver. It issues periodic `dataRequest` pulses to the receiver and captures each returned 12-bit word on the rising edge of `spiReady`. After every 2^LOG2_AVG words it presents a 12-bit mean to the telemetry framer. A lost conversion is detected by a timeout and reported without corrupting the running average.

## Interface
- `PERIOD`, 16'd800 — clk cycles from one request start to the next; must be ≥ 8.
- `LOG2_AVG`, 3 — log2 of the number of samples averaged, range 0..4.
- `TIMEOUT`, 10'd600 — clk cycles to wait for `spiReady` after the request ends.
- `clk` in 1 — system clock, 80 MHz.
- `reset` in 1 — asynchronous, active-low reset.
- `enable` in 1 — run request schedule while high.
- `spiData` in 12 — parallel word from receiver.
- `spiReady` in 1 — receiver data-ready, high for ≥1 cycle per word.
- `dataRequest` out 1 — conversion request to receiver. Reset value: 0.
- `avgData` out 12 — latest average, held until the next update. Reset value: 0.
- `avgValid` out 1 — one-cycle pulse when `avgData` updates. Reset value: 0.
- `timeoutErr` out 1 — one-cycle pulse when a request goes unanswered. Reset value: 0.

## Operation
- `spiReady` is registered every cycle into `rdyD`.
  - `rdyEdge = spiReady & ~rdyD`.
  - Only `rdyEdge` counts. A level already high on entry to WAIT is ignored.
- Accumulator `acc` is 12+LOG2_AVG bits wide. Sample counter `cnt` is LOG2_AVG bits wide (1 bit when LOG2_AVG=0). Both reset to 0.
- State machine (reset state is IDLE):
  - **IDLE**: `dataRequest`=0. If `enable`, go to REQ and clear the period counter `per`.
  - **REQ**: `dataRequest`=1 for exactly 4 cycles, then go to WAIT and clear the timeout counter `tmo`.
  - **WAIT**: `tmo` increments each cycle.
    - On `rdyEdge`: `acc <= acc + spiData`.
    - If `cnt` = 2^LOG2_AVG−1, go to DONE. Otherwise `cnt++` and go to HOLD.
    - If `tmo` = TIMEOUT−1 with no edge: pulse `timeoutErr`, discard the sample (`acc` and `cnt` unchanged), go to HOLD.
  - **DONE** (1 cycle):
    - `avgData <= (acc + RND) >> LOG2_AVG`.
    - Pulse `avgValid`.
    - Clear `acc` and `cnt`.
    - Go to HOLD.
  - **HOLD**: wait until `per` ≥ PERIOD−1, then go to REQ and clear `per`.
- `per` increments every cycle outside IDLE and saturates at PERIOD−1. If a conversion outlasts PERIOD, the next request starts the cycle after HOLD is entered (deferred, never dropped or overlapped).
- `enable` low in any state except IDLE:
  - Next state is IDLE.
  - `dataRequest` drops the next cycle.
  - `acc` and `cnt` are cleared.
  - A late `spiReady` is ignored.
  - `avgData` is retained.
- `rdyEdge` is ignored in IDLE, REQ, HOLD and DONE.
- Arithmetic: the sum is unsigned and cannot overflow (4095·16 + 8 < 2^16). The result fits in 12 bits.
- Asynchronous reset mid-operation returns to IDLE. All outputs and all counters go to 0 immediately.

## Timing
- First request: `dataRequest` rises 1 cycle after `enable` is sampled high in IDLE.
- Request pulse width is 4 cycles, which exceeds the receiver's 3-stage synchroniser.
- Request period is exactly PERIOD cycles when every conversion completes within PERIOD−5 cycles.
- Sample latency: if `rdyEdge` occurs in cycle t, `acc` holds the new sum at t+1.
- Average latency: on the last sample, `avgValid`=1 and `avgData` is valid in cycle t+2.
- Timeout: `timeoutErr` pulses in cycle (request end + TIMEOUT).

## Configuration
- `AVG_ROUND_EN`:
  - Defined: RND = 2^(LOG2_AVG−1) (round half up). RND = 0 when LOG2_AVG=0.
  - Undefined: RND = 0 (truncation).
  - No other behaviour changes.

## Test plan
- Reset with `enable`=1 held → all outputs 0 while `reset`=0. After release, `dataRequest` goes high for 4 cycles, then again exactly 800 cycles after its previous rise.
- Model returns 100,101,102,103,104,105,106,107 (LOG2_AVG=3) → `avgData`=103 with the macro undefined (sum 828), and 104 with `AVG_ROUND_EN` defined. `avgValid` pulses once, 2 cycles after the 8th `spiReady` edge.
- Model withholds the 3rd reply → `timeoutErr` pulses 600 cycles after that request ends. The next 6 replies of 4095 plus 2 earlier of 4095 give `avgData`=4095 with no overflow.
- `spiReady` held high for 4 cycles per word, and also already high at WAIT entry → exactly one accumulation per rising edge; the stale level is not counted.
- Model replies after 900 cycles with PERIOD=800 → the next `dataRequest` rises the cycle after HOLD is entered, with no overlapping request.
- `enable` dropped after 5 samples, reply arrives afterwards → ignored. Re-enable followed by 8 replies of 200 gives `avgData`=200; the partial sum was cleared.
